// File: rtl/chk192_seqlock.sv
// Receive-side sequence/payload checker for the 8-lane PCS loopback bench.
// Hunts for a self-consistent word, then tracks the incrementing sequence and counts faults.

module chk192_lane #(
  parameter int K = 0
) (
  input  logic [31:0] seq,
  input  logic [31:0] pay,
  output logic        ok
);
  assign ok = (pay == seq + 32'(K + 1));
endmodule

module chk192_seqlock #(
  parameter int LOSS_THRESH = 4,
  parameter int GOOD_THRESH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rcvtime,
  input  logic [191:0] data,
  input  logic         pop,
  output logic         locked,
  output logic         correct,
  output logic [31:0]  word_cnt,
  output logic [15:0]  seq_err_cnt,
  output logic [15:0]  data_err_cnt
);
  localparam int NUM_LANES = 5;
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);
  localparam logic [7:0] GOOD_T = 8'(GOOD_THRESH);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [31:0]   expected_q, expected_d;
  logic [3:0]    bad_run_q, bad_run_d;
  logic [7:0]    good_run_q, good_run_d;
  logic          err_seen_q, err_seen_d;
  logic          rcvtime_q;
  logic          correct_q, correct_d;
  logic [31:0]   word_cnt_q, word_cnt_d;
  logic [15:0]   seq_err_q, seq_err_d;
  logic [15:0]   data_err_q, data_err_d;

  logic [31:0]          seq;
  logic [NUM_LANES-1:0] lane_ok;
  logic                 consistent;
  logic                 accept;
  logic                 rise;

  assign seq = data[191:160];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    chk192_lane #(.K(k)) u_lane (
      .seq (seq),
      .pay (data[32*k +: 32]),
      .ok  (lane_ok[k])
    );
  end

  assign consistent = &lane_ok;
  assign accept     = pop && rcvtime;
  assign rise       = rcvtime && !rcvtime_q;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    bad_run_d  = bad_run_q;
    good_run_d = good_run_q;
    err_seen_d = err_seen_q;
    word_cnt_d = word_cnt_q;
    seq_err_d  = seq_err_q;
    data_err_d = data_err_q;

    // Window opening wipes results first, so a same-cycle word is a fresh HUNT word.
    if (rise) begin
      state_d    = HUNT;
      bad_run_d  = '0;
      good_run_d = '0;
      err_seen_d = 1'b0;
      word_cnt_d = '0;
      seq_err_d  = '0;
      data_err_d = '0;
    end

    if (accept) begin
      if (state_d == HUNT) begin
        if (consistent) begin
          state_d    = LOCKED;
          expected_d = seq + 32'd1;
          bad_run_d  = '0;
          good_run_d = '0;
          err_seen_d = 1'b0;
        end
      end else begin
        if (seq != expected_d) begin
          // Sequence fault takes precedence over any payload fault in the same word.
          seq_err_d  = (seq_err_d == '1) ? seq_err_d : seq_err_d + 16'd1;
          expected_d = seq + 32'd1;
          bad_run_d  = bad_run_d + 4'd1;
          good_run_d = '0;
          err_seen_d = 1'b1;
        end else if (consistent) begin
          word_cnt_d = (word_cnt_d == '1) ? word_cnt_d : word_cnt_d + 32'd1;
          good_run_d = (good_run_d == '1) ? good_run_d : good_run_d + 8'd1;
          bad_run_d  = '0;
          expected_d = expected_d + 32'd1;
        end else begin
          data_err_d = (data_err_d == '1) ? data_err_d : data_err_d + 16'd1;
          expected_d = expected_d + 32'd1;
          bad_run_d  = bad_run_d + 4'd1;
          good_run_d = '0;
          err_seen_d = 1'b1;
        end
        if (bad_run_d == LOSS_T) begin
          state_d   = HUNT;
          bad_run_d = '0;
        end
      end
    end

    correct_d = (state_d == LOCKED) && !err_seen_d && (good_run_d >= GOOD_T);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      expected_q <= '0;
      bad_run_q  <= '0;
      good_run_q <= '0;
      err_seen_q <= 1'b0;
      rcvtime_q  <= 1'b0;
      correct_q  <= 1'b0;
      word_cnt_q <= '0;
      seq_err_q  <= '0;
      data_err_q <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      bad_run_q  <= bad_run_d;
      good_run_q <= good_run_d;
      err_seen_q <= err_seen_d;
      rcvtime_q  <= rcvtime;
      correct_q  <= correct_d;
      word_cnt_q <= word_cnt_d;
      seq_err_q  <= seq_err_d;
      data_err_q <= data_err_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign correct      = correct_q;
  assign word_cnt     = word_cnt_q;
  assign seq_err_cnt  = seq_err_q;
  assign data_err_cnt = data_err_q;
endmodule
